// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side signals of the shared memory port.
// The arbiter takes the slave view; caches and RAM take the master view.
interface cache_mem_arbiter_if #(
    parameter int NCORES = 2,
    parameter int WORD_W = 32
);
    logic [NCORES-1:0]             iREN;
    logic [NCORES-1:0]             dREN;
    logic [NCORES-1:0]             dWEN;
    logic [NCORES-1:0][WORD_W-1:0] iaddr;
    logic [NCORES-1:0][WORD_W-1:0] daddr;
    logic [NCORES-1:0][WORD_W-1:0] dstore;
    logic [NCORES-1:0]             iwait;
    logic [NCORES-1:0]             dwait;
    logic [NCORES-1:0][WORD_W-1:0] iload;
    logic [NCORES-1:0][WORD_W-1:0] dload;
    logic                          ramREN;
    logic                          ramWEN;
    logic [WORD_W-1:0]             ramaddr;
    logic [WORD_W-1:0]             ramstore;
    logic [WORD_W-1:0]             ramload;
    logic [1:0]                    ramstate;

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between the icache/dcache of two cores: data over
// instruction, round-robin between cores, one registered grant at a time.
//
//   state | meaning
//   IDLE  | no grant; RAM strobes low; arbitrate pending requests
//   SERVE | granted requester drives the RAM until ACCESS, ERROR or withdrawal
module cache_mem_arbiter #(
    parameter int NCORES = 2,
    parameter int WORD_W = 32
) (
    input logic                  CLK,
    input logic                  nRST,
    cache_mem_arbiter_if.slave   bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE, SERVE} state_t;

    state_t state_q, state_d;
    logic   gcore_q, gcore_d;
    logic   gdata_q, gdata_d;
    logic   rr_q, rr_d;

    logic [NCORES-1:0] dreq;
    logic              grant_live;
    logic              ren_c, wen_c;
    logic [WORD_W-1:0] addr_c, store_c;
    logic [NCORES-1:0] iwait_c, dwait_c;

    // Only called when at least one bit of req is set.
    function automatic logic pick(input logic [NCORES-1:0] req, input logic pref);
        return req[pref] ? pref : ~pref;
    endfunction

    assign dreq = bus.dREN | bus.dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gcore_q <= 1'b0;
            gdata_q <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gcore_q <= gcore_d;
            gdata_q <= gdata_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gcore_d    = gcore_q;
        gdata_d    = gdata_q;
        rr_d       = rr_q;
        ren_c      = 1'b0;
        wen_c      = 1'b0;
        addr_c     = '0;
        store_c    = '0;
        iwait_c    = '1;
        dwait_c    = '1;
        grant_live = gdata_q ? dreq[gcore_q] : bus.iREN[gcore_q];

        unique case (state_q)
            IDLE: begin
                if (|dreq) begin
                    gdata_d = 1'b1;
                    gcore_d = pick(dreq, rr_q);
                    state_d = SERVE;
                end else if (|bus.iREN) begin
                    gdata_d = 1'b0;
                    gcore_d = pick(bus.iREN, rr_q);
                    state_d = SERVE;
                end
            end
            SERVE: begin
                // A withdrawn request leaves the strobes low and drops the grant.
                if (!grant_live) begin
                    state_d = IDLE;
                end else begin
                    if (gdata_q) begin
                        wen_c   = bus.dWEN[gcore_q];
                        ren_c   = bus.dREN[gcore_q] & ~bus.dWEN[gcore_q];
                        addr_c  = bus.daddr[gcore_q];
                        store_c = bus.dstore[gcore_q];
                    end else begin
                        ren_c   = 1'b1;
                        addr_c  = bus.iaddr[gcore_q];
                    end
                    if (bus.ramstate == RAM_ACCESS) begin
                        if (gdata_q) dwait_c[gcore_q] = 1'b0;
                        else         iwait_c[gcore_q] = 1'b0;
                        rr_d    = ~gcore_q;
                        state_d = IDLE;
                    end else if (bus.ramstate == RAM_ERROR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ramREN   = ren_c;
    assign bus.ramWEN   = wen_c;
    assign bus.ramaddr  = addr_c;
    assign bus.ramstore = store_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = {NCORES{bus.ramload}};
    assign bus.dload    = {NCORES{bus.ramload}};
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed scenarios plus randomized cache/RAM traffic, checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_cache_mem_arbiter;
    localparam int NC = 2;
    localparam int W  = 32;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    cache_mem_arbiter_if #(.NCORES(NC), .WORD_W(W)) bus ();
    cache_mem_arbiter #(.NCORES(NC), .WORD_W(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // model: who holds the RAM and who is preferred on a tie
    bit   m_busy, m_data, m_live, m_done;
    int   m_core, m_pref;
    logic [1:0] last_iw = 2'b11;
    logic [1:0] last_dw = 2'b11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] req, input int pref);
        if (req[pref])     return pref;
        if (req[1 - pref]) return 1 - pref;
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
    endtask

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_core = 0; m_pref = 0;
        m_live = 0; m_done = 0;
        last_iw = 2'b11; last_dw = 2'b11;
    endtask

    // Check this cycle's combinational outputs against the model.
    task automatic eval();
        logic [1:0]  e_iw, e_dw;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        e_iw = 2'b11; e_dw = 2'b11; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        m_live = 0; m_done = 0;
        #1;
        if (m_busy) begin
            m_live = m_data ? (bus.dREN[m_core] | bus.dWEN[m_core]) : bus.iREN[m_core];
            if (m_live) begin
                if (m_data) begin
                    e_wen   = bus.dWEN[m_core];
                    e_ren   = bus.dREN[m_core] & ~bus.dWEN[m_core];
                    e_addr  = bus.daddr[m_core];
                    e_store = bus.dstore[m_core];
                end else begin
                    e_ren  = 1'b1;
                    e_addr = bus.iaddr[m_core];
                end
                if (bus.ramstate == ACCESS) begin
                    m_done = 1;
                    if (m_data) e_dw[m_core] = 1'b0;
                    else        e_iw[m_core] = 1'b0;
                end
            end
        end
        chk("ramREN",   32'(bus.ramREN), 32'(e_ren));
        chk("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
        chk("ramaddr",  bus.ramaddr, e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("iwait",    32'(bus.iwait), 32'(e_iw));
        chk("dwait",    32'(bus.dwait), 32'(e_dw));
        for (int c = 0; c < NC; c++) begin
            if (!e_iw[c]) chk("iload", bus.iload[c], bus.ramload);
            if (!e_dw[c]) chk("dload", bus.dload[c], bus.ramload);
        end
        last_iw = e_iw;
        last_dw = e_dw;
    endtask

    // Advance the model across the rising edge and return at the next falling edge.
    task automatic tick();
        int w;
        @(posedge CLK);
        if (m_busy) begin
            if (!m_live || bus.ramstate == ACCESS || bus.ramstate == ERROR) m_busy = 0;
            if (m_done) m_pref = 1 - m_core;
        end else begin
            w = pick(bus.dREN | bus.dWEN, m_pref);
            if (w >= 0) begin
                m_busy = 1; m_data = 1; m_core = w;
            end else begin
                w = pick(bus.iREN, m_pref);
                if (w >= 0) begin
                    m_busy = 1; m_data = 0; m_core = w;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic cycle();
        eval();
        tick();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic rand_drive();
        int  k;
        bit  dropped;
        for (int c = 0; c < NC; c++) begin
            dropped = 0;
            if (!last_iw[c]) bus.iREN[c] = 1'b0;
            if (!last_dw[c]) begin
                bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0;
            end else if ((bus.dREN[c] | bus.dWEN[c]) && $urandom_range(0, 29) == 0) begin
                bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0; dropped = 1;
            end
            if (!bus.iREN[c] && $urandom_range(0, 3) == 0) begin
                bus.iREN[c] = 1'b1; bus.iaddr[c] = $urandom;
            end
            if (!dropped && !(bus.dREN[c] | bus.dWEN[c]) && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(1, 3);
                bus.dREN[c] = k[0]; bus.dWEN[c] = k[1];
                bus.daddr[c] = $urandom; bus.dstore[c] = $urandom;
            end
        end
        bus.ramload = $urandom;
        k = $urandom_range(0, 9);
        bus.ramstate = (k < 4) ? BUSY : (k < 8) ? ACCESS : (k == 8) ? FREE : ERROR;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        nRST = 1'b0;
        #12;
        chk("rst_ren",   32'(bus.ramREN), 32'd0);
        chk("rst_wen",   32'(bus.ramWEN), 32'd0);
        chk("rst_addr",  bus.ramaddr, 32'd0);
        chk("rst_store", bus.ramstore, 32'd0);
        chk("rst_iwait", 32'(bus.iwait), 32'd3);
        chk("rst_dwait", 32'(bus.dwait), 32'd3);
        @(negedge CLK);
        nRST = 1'b1;

        // single fetch, two BUSY cycles then ACCESS
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100; bus.ramstate = BUSY;
        eval(); chk("f_idle_ren", 32'(bus.ramREN), 32'd0); tick();
        eval(); chk("f_b1_ren", 32'(bus.ramREN), 32'd1); chk("f_b1_addr", bus.ramaddr, 32'h100); tick();
        eval(); chk("f_b2_ren", 32'(bus.ramREN), 32'd1); chk("f_b2_iw", 32'(bus.iwait), 32'd3); tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
        eval(); chk("f_iwait", 32'(bus.iwait), 32'd2); chk("f_iload", bus.iload[0], 32'hDEADBEEF);
        chk("f_acc_addr", bus.ramaddr, 32'h100); tick();
        bus.iREN[0] = 1'b0; bus.ramstate = FREE;
        eval(); chk("f_back_idle", 32'(bus.ramREN), 32'd0); tick();

        // data beats instruction on the same core
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h180;
        bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.ramstate = ACCESS;
        cycle();
        eval(); chk("p_data_addr", bus.ramaddr, 32'h200); chk("p_dwait", 32'(bus.dwait), 32'd2); tick();
        bus.dREN[0] = 1'b0;
        eval(); chk("p_gap", 32'(bus.ramREN), 32'd0); tick();
        eval(); chk("p_inst_addr", bus.ramaddr, 32'h180); chk("p_iwait", 32'(bus.iwait), 32'd2); tick();
        bus.iREN[0] = 1'b0;
        cycle();

        // round-robin writes from reset: core0, core1, core0
        do_reset();
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h300; bus.dstore[0] = 32'hAAAA0000;
        bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h400; bus.dstore[1] = 32'hBBBB1111;
        bus.ramstate = ACCESS;
        for (int k = 0; k < 3; k++) begin
            eval(); chk("rr_gap", 32'(bus.ramWEN), 32'd0); tick();
            eval();
            chk("rr_addr",  bus.ramaddr, (k == 1) ? 32'h400 : 32'h300);
            chk("rr_store", bus.ramstore, (k == 1) ? 32'hBBBB1111 : 32'hAAAA0000);
            chk("rr_wen",   32'(bus.ramWEN), 32'd1);
            chk("rr_dwait", 32'(bus.dwait), (k == 1) ? 32'd1 : 32'd2);
            tick();
        end
        bus.dWEN = '0;
        cycle();

        // write wins over read (core0 completes, pointer moves to core1)
        bus.dREN[0] = 1'b1; bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h500; bus.dstore[0] = 32'h55;
        cycle();
        eval(); chk("wr_wen", 32'(bus.ramWEN), 32'd1); chk("wr_ren", 32'(bus.ramREN), 32'd0); tick();
        bus.dREN[0] = 1'b0; bus.dWEN[0] = 1'b0;
        cycle();

        // core1 withdraws its read mid-BUSY; pointer must stay on core1
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h600; bus.ramstate = BUSY;
        cycle();
        eval(); chk("ab_busy_ren", 32'(bus.ramREN), 32'd1); tick();
        bus.dREN[1] = 1'b0;
        eval(); chk("ab_ren", 32'(bus.ramREN), 32'd0); chk("ab_dwait", 32'(bus.dwait), 32'd3); tick();
        eval(); chk("ab_idle", 32'(bus.ramREN), 32'd0); tick();
        bus.dREN = 2'b11; bus.daddr[0] = 32'h700; bus.daddr[1] = 32'h710; bus.ramstate = ACCESS;
        cycle();
        eval(); chk("ab_rr_keep", bus.ramaddr, 32'h710); tick();
        bus.dREN[1] = 1'b0;
        cycle(); cycle();
        bus.dREN[0] = 1'b0;
        cycle();

        // ERROR releases nothing and the same fetch is granted again
        bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h800; bus.ramstate = ERROR;
        cycle();
        eval(); chk("er_iwait", 32'(bus.iwait), 32'd3); chk("er_ren", 32'(bus.ramREN), 32'd1); tick();
        bus.ramstate = ACCESS;
        eval(); chk("er_idle", 32'(bus.ramREN), 32'd0); tick();
        eval(); chk("er_retry_addr", bus.ramaddr, 32'h800); chk("er_retry_iw", 32'(bus.iwait), 32'd1); tick();
        bus.iREN[1] = 1'b0;
        cycle();

        // reset lands mid-SERVE with the pointer on core1
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h900;
        cycle(); cycle();
        bus.iREN[0] = 1'b0;
        bus.iREN[1] = 1'b1; bus.iaddr[1] = 32'h910; bus.ramstate = BUSY;
        cycle();
        eval(); chk("rs_pre_ren", 32'(bus.ramREN), 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("rs_ren",   32'(bus.ramREN), 32'd0);
        chk("rs_addr",  bus.ramaddr, 32'd0);
        chk("rs_iwait", 32'(bus.iwait), 32'd3);
        chk("rs_dwait", 32'(bus.dwait), 32'd3);
        clear_inputs();
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        bus.dREN = 2'b11; bus.daddr[0] = 32'hA00; bus.daddr[1] = 32'hA10; bus.ramstate = ACCESS;
        cycle();
        eval(); chk("rs_rr_zero", bus.ramaddr, 32'hA00); tick();
        bus.dREN = '0;
        cycle();

        // randomized traffic
        clear_inputs();
        cycle();
        for (int n = 0; n < 4000; n++) begin
            rand_drive();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbiter and sequencer between the per-core instruction and data caches and the single shared RAM port in the multicore memory system. It owns the one RAM request path and serves one cache at a time through a registered grant. Data beats instruction, and the two cores alternate round-robin. Each cache sees its usual iwait/dwait handshake; the RAM is driven via ramREN/ramWEN/ramaddr/ramstore and paced by ramstate.

## Interface
Parameters:
- NCORES, 2, number of cores (cache pairs); this revision supports exactly 2
- WORD_W, 32, data/address width (word_t)

Ports (per-core buses are NCORES-entry arrays, index = CPUID):
- CLK  in  1  system clock, all state on rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN[c]  in  1  instruction fetch request from core c icache
- iaddr[c]  in  32  instruction address
- dREN[c]  in  1  data read request from core c dcache
- dWEN[c]  in  1  data write request from core c dcache
- daddr[c]  in  32  data address
- dstore[c]  in  32  write data
- iwait[c]  out  1  0 only in the cycle core c's fetch completes
- dwait[c]  out  1  0 only in the cycle core c's data access completes
- iload[c]  out  32  fetched word, valid when iwait[c]=0
- dload[c]  out  32  read word, valid when dwait[c]=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (completes this cycle), 3 ERROR

## Operation
- Requests: each requester holds its request, address and store data stable until its wait goes low. If a requester raises both dWEN and dREN, the access is a write.
- State: FSM {IDLE, SERVE}, plus grant registers gcore (1b) and gdata (1b), and round-robin pointer rr (1b; the core preferred on a tie).
- IDLE:
  - RAM strobes are 0.
  - If any request is pending, pick a winner, latch gcore/gdata, and go to SERVE.
  - Priority: any data request beats any instruction request. Among requests of the same class, core rr wins if it requests; otherwise the other core wins.
  - With no request, stay in IDLE.
- SERVE:
  - Drive the RAM from the granted requester's live signals.
  - Data grant: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
  - Instruction grant: ramREN=1, ramaddr=iaddr, ramstore=0.
- Completion: ramstate==ACCESS in SERVE.
  - Drive the granted wait low combinationally in the same cycle.
  - Next state IDLE; rr <= ~gcore.
- ERROR in SERVE: no wait is released; return to IDLE with rr unchanged. The requester is re-arbitrated, which gives an automatic retry.
- Abort: if the granted requester drops its request while in SERVE (a dcache request can be withdrawn, e.g. on invalidate), deassert the RAM strobes in that cycle and return to IDLE. No wait is released and rr is unchanged.
- Load outputs: iload[c] and dload[c] = ramload at all times. Consumers sample them only when their wait is 0.
- All non-granted waits stay 1, including requesters that are not requesting.

## Timing
- Reset values: state IDLE, gcore=0, gdata=0, rr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait/dwait=1.
- Reset asserted mid-SERVE: the RAM strobes drop immediately (asynchronous) and the in-flight access is lost; requesters re-request after reset.
- Latency: a request seen in IDLE at cycle t puts RAM strobes out at t+1. With ramstate=ACCESS at t+1, wait is low at t+1; the minimum is 2 cycles per access.
- Each BUSY cycle adds one cycle. There is no watchdog; a RAM that stays BUSY holds the grant indefinitely.
- Back-to-back: at least one IDLE cycle between grants.
- Fairness: under continuous contention, each class alternates between cores per completed access. Instruction fetches wait behind pending data accesses; the system relies on data traffic gaps to avoid instruction starvation.
- A new request arriving during SERVE is not considered until the next IDLE.

## Test plan
- Single fetch: core0 iREN=1, iaddr=0x100, RAM answers ACCESS after 2 BUSY cycles with 0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 3 cycles; iwait[0]=0 and iload[0]=0xDEADBEEF in the 4th cycle after the request; back to IDLE.
- Class priority: core0 iREN and dREN (daddr=0x200) both raised at the same cycle -> data served first (ramaddr=0x200), fetch granted after the next IDLE.
- Round-robin: both cores hold dWEN (0x300/0x400) continuously from reset -> grant order core0, core1, core0; each write completes with ramWEN=1, correct ramstore, one dwait pulse per grant.
- Write over read: dREN=dWEN=1 -> ramWEN=1, ramREN=0.
- Abort: core1 dREN dropped during the BUSY phase -> strobes 0 that cycle, dwait[1] never low, IDLE next cycle, rr unchanged.
- Error and reset: ramstate=ERROR during SERVE -> no wait pulse, same requester regranted. nRST low mid-SERVE -> strobes 0 immediately, all waits 1, state IDLE, rr=0.
